// File: rtl/prach_buffer_pkg.sv
// Shared constants and helpers for the single-clock PRACH CP buffer.
package prach_buffer_pkg;

  localparam int AFULL_MARGIN = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prach_buffer_sdpram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port, no reset.
module prach_buffer_sdpram
  import prach_buffer_pkg::*;
#(
  parameter int WIDTH = 144,
  parameter int DEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      wr_en_i,
  input  logic [ptr_w(DEPTH)-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic [ptr_w(DEPTH)-1:0]   rd_addr_i,
  output logic [WIDTH-1:0]          rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/prach_buffer_cp_sfifo.sv
// Single-clock show-ahead FIFO for the PRACH CP path with fill level, almost-full and flush.
// Define PRACH_BUFFER_CP_SFIFO_OREG_EN to feed rd_data/rd_valid from a one-entry prefetch register.
module prach_buffer_cp_sfifo
  import prach_buffer_pkg::*;
#(
  parameter int WIDTH        = 144,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - AFULL_MARGIN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_valid,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    wr_ready,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ptr_w(DEPTH):0]   level,
  output logic                    almost_full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_THRESH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             afull_q, afull_d;
  logic             wr_en, rd_en, ram_rd_en;
  logic [WIDTH-1:0] ram_rdata;

  assign wr_ready = ~rst & ~flush & (level_q != FULL_LVL);
  assign wr_en    = wr_valid & wr_ready;
  assign rd_en    = rd_valid & rd_ready;

  prach_buffer_sdpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rptr_q),
    .rd_data_o (ram_rdata)
  );

`ifdef PRACH_BUFFER_CP_SFIFO_OREG_EN
  logic             pf_vld_q, pf_vld_d;
  logic [WIDTH-1:0] pf_dat_q, pf_dat_d;
  logic             ram_has;

  // level includes the prefetch entry, so the RAM holds level minus that entry
  assign ram_has   = level_q > LW'(pf_vld_q);
  assign ram_rd_en = ram_has & (~pf_vld_q | rd_en) & ~flush;
  assign rd_valid  = pf_vld_q & ~flush;
  assign rd_data   = pf_dat_q;

  always_comb begin
    pf_vld_d = pf_vld_q;
    pf_dat_d = pf_dat_q;
    if (flush) begin
      pf_vld_d = 1'b0;
    end else if (ram_rd_en) begin
      pf_vld_d = 1'b1;
      pf_dat_d = ram_rdata;
    end else if (rd_en) begin
      pf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_vld_q <= 1'b0;
      pf_dat_q <= '0;
    end else begin
      pf_vld_q <= pf_vld_d;
      pf_dat_q <= pf_dat_d;
    end
  end
`else
  assign ram_rd_en = rd_en;
  assign rd_valid  = (level_q != '0) & ~flush;
  assign rd_data   = ram_rdata;
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en)     wptr_d = wptr_q + PW'(1);
      if (ram_rd_en) rptr_d = rptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    afull_d = (level_d >= AFULL_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign level       = level_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_prach_buffer_cp_sfifo.sv
// Self-checking bench: queue model with per-word write timestamps for read visibility.
module tb_prach_buffer_cp_sfifo;

  localparam int WIDTH  = 144;
  localparam int DEPTH  = 16;
  localparam int THRESH = DEPTH - 4;
  localparam int LW     = $clog2(DEPTH) + 1;
`ifdef PRACH_BUFFER_CP_SFIFO_OREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, wr_valid, wr_ready, rd_valid, rd_ready, almost_full;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic [LW-1:0]    level;

  int checks = 0;
  int errors = 0;

  // model: words held, and the edge count at which each was written
  logic [WIDTH-1:0] mq[$];
  int               mt[$];
  int               tnow = 0;

  logic             o_wr_ready, o_rd_valid, o_af, e_wr_ready, e_rd_valid, e_af;
  logic [LW-1:0]    o_level, e_level;
  logic [WIDTH-1:0] o_rd_data, e_rd_data;

  always #5 clk = ~clk;

  prach_buffer_cp_sfifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AFULL_THRESH (THRESH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .level       (level),
    .almost_full (almost_full)
  );

  // One clock: drive after the falling edge, snapshot DUT and model, advance model at the rising edge.
  task automatic step(input logic wv, input logic [WIDTH-1:0] wd, input logic rr, input logic fl);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    #1;
    o_wr_ready = wr_ready; o_rd_valid = rd_valid; o_af = almost_full;
    o_level = level; o_rd_data = rd_data;
    e_level    = LW'(mq.size());
    e_af       = (mq.size() >= THRESH);
    e_wr_ready = !fl && (mq.size() < DEPTH);
    e_rd_valid = !fl && (mq.size() > 0) && (tnow >= mt[0] + LAT);
    e_rd_data  = e_rd_valid ? mq[0] : '0;
    @(posedge clk);
    tnow++;
    if (fl) begin
      mq.delete(); mt.delete();
    end else begin
      if (e_rd_valid && rr) begin void'(mq.pop_front()); void'(mt.pop_front()); end
      if (e_wr_ready && wv) begin mq.push_back(wd); mt.push_back(tnow); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b1; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_ready, rd_valid, almost_full, level} !== '0) begin
      errors++;
      $display("FAIL reset_state: got wr_ready=%b rd_valid=%b afull=%b level=%0d required all 0",
               wr_ready, rd_valid, almost_full, level);
    end
    rst = 1'b0;
    mq.delete(); mt.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      checks++;
      if ({o_wr_ready, o_rd_valid, o_af, o_level} !== {e_wr_ready, e_rd_valid, e_af, e_level}) begin
        errors++;
        $display("FAIL fill_flags: got rdy/vld/af/lvl %b %b %b %0d required %b %b %b %0d",
                 o_wr_ready, o_rd_valid, o_af, o_level, e_wr_ready, e_rd_valid, e_af, e_level);
      end
      if (e_rd_valid) begin
        checks++;
        if (o_rd_data !== e_rd_data) begin
          errors++; $display("FAIL fill_data: got %0h required %0h", o_rd_data, e_rd_data);
        end
      end
    end
    #1;
    checks++;
    if (level !== LW'(16) || wr_ready !== 1'b0 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got level=%0d wr_ready=%b afull=%b required 16 0 1",
               level, wr_ready, almost_full);
    end
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if ({o_wr_ready, o_rd_valid, o_af, o_level} !== {e_wr_ready, e_rd_valid, e_af, e_level}) begin
        errors++;
        $display("FAIL drain_flags: got rdy/vld/af/lvl %b %b %b %0d required %b %b %b %0d",
                 o_wr_ready, o_rd_valid, o_af, o_level, e_wr_ready, e_rd_valid, e_af, e_level);
      end
      if (e_rd_valid) begin
        checks++;
        if (o_rd_data !== e_rd_data) begin
          errors++; $display("FAIL drain_data: got %0h required %0h", o_rd_data, e_rd_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, WIDTH'(108 + i), 1'b1, 1'b0);
      checks++;
      if (o_level !== LW'(8) || o_rd_valid !== 1'b1 || o_rd_data !== WIDTH'(100 + i)) begin
        errors++;
        $display("FAIL steady_state: cycle %0d got level=%0d vld=%b data=%0h required 8 1 %0h",
                 i, o_level, o_rd_valid, o_rd_data, 100 + i);
      end
    end
  endtask

  task automatic test_full_stall();
    while (mq.size() < DEPTH) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'hBEEF), 1'b1, 1'b0);
    checks++;
    if (o_wr_ready !== 1'b0 || o_rd_valid !== 1'b1 || o_rd_data !== e_rd_data) begin
      errors++;
      $display("FAIL full_stall_cycle: got rdy=%b vld=%b data=%0h required 0 1 %0h",
               o_wr_ready, o_rd_valid, o_rd_data, e_rd_data);
    end
    step(1'b1, WIDTH'(16'hBEEF), 1'b0, 1'b0);
    checks++;
    if (o_level !== LW'(15) || o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_stall_read_only: got level=%0d rdy=%b required 15 1", o_level, o_wr_ready);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (o_level !== LW'(16)) begin
      errors++; $display("FAIL full_stall_refill: got level=%0d required 16", o_level);
    end
  endtask

  task automatic test_empty_stall();
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, WIDTH'(8'hA5), 1'b1, 1'b0);
    checks++;
    if (o_rd_valid !== 1'b0 || o_level !== '0) begin
      errors++;
      $display("FAIL empty_stall_cycle: got vld=%b level=%0d required 0 0", o_rd_valid, o_level);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (o_rd_valid !== (i >= LAT) || (o_rd_valid && o_rd_data !== WIDTH'(8'hA5))) begin
        errors++;
        $display("FAIL empty_stall_latency: +%0d got vld=%b data=%0h required vld=%b data a5",
                 i + 1, o_rd_valid, o_rd_data, i >= LAT);
      end
    end
  endtask

  task automatic test_flush();
    while (mq.size() < 7) step(1'b1, WIDTH'(200 + mq.size()), 1'b0, 1'b0);
    step(1'b1, WIDTH'(300), 1'b1, 1'b1);
    checks++;
    if (o_wr_ready !== 1'b0 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: got rdy=%b vld=%b required 0 0", o_wr_ready, o_rd_valid);
    end
    step(1'b1, WIDTH'(1), 1'b0, 1'b0);
    checks++;
    if (o_level !== '0 || o_rd_valid !== 1'b0 || o_af !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got level=%0d vld=%b af=%b required 0 0 0", o_level, o_rd_valid, o_af);
    end
    repeat (LAT) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== WIDTH'(1) || o_level !== LW'(1)) begin
      errors++;
      $display("FAIL flush_first_word: got vld=%b data=%0h level=%0d required 1 1 1",
               o_rd_valid, o_rd_data, o_level);
    end
  endtask

  task automatic test_async_reset();
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(400 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wr_ready, rd_valid, almost_full, level} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b vld=%b af=%b level=%0d required all 0",
               wr_ready, rd_valid, almost_full, level);
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); mt.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if ({o_wr_ready, o_rd_valid, o_af, o_level} !== {1'b1, 1'b0, 1'b0, LW'(0)}) begin
        errors++;
        $display("FAIL post_reset_idle: got rdy/vld/af/lvl %b %b %b %0d required 1 0 0 0",
                 o_wr_ready, o_rd_valid, o_af, o_level);
      end
    end
  endtask

  task automatic test_random();
    logic wv, rr, fl;
    for (int i = 0; i < 800; i++) begin
      wv = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 75));
      fl = ($urandom_range(0, 59) == 0);
      step(wv, {$urandom, $urandom, $urandom, $urandom, $urandom}, rr, fl);
      checks++;
      if ({o_wr_ready, o_rd_valid, o_af, o_level} !== {e_wr_ready, e_rd_valid, e_af, e_level}) begin
        errors++;
        $display("FAIL random_flags: cycle %0d got rdy/vld/af/lvl %b %b %b %0d required %b %b %b %0d",
                 i, o_wr_ready, o_rd_valid, o_af, o_level, e_wr_ready, e_rd_valid, e_af, e_level);
      end
      if (e_rd_valid) begin
        checks++;
        if (o_rd_data !== e_rd_data) begin
          errors++; $display("FAIL random_data: cycle %0d got %0h required %0h", i, o_rd_data, e_rd_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_full_stall();
    test_empty_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prach_buffer_cp_sfifo.md
# prach_buffer_cp_sfifo

Single-clock, parametrised, show-ahead FIFO with native RTL storage. It replaces the dual-clock vendor-IP CP buffer wherever the write and read sides of the PRACH CP path share one clock. Compared with that buffer it adds a fill level, a programmable almost-full flag, a synchronous flush and an optional output register stage.

## Interface
- `WIDTH`, 144: data word width in bits.
- `DEPTH`, 16: capacity in words; must be a power of two and ≥ 4.
- `AFULL_THRESH`, DEPTH-4: `almost_full` asserts when `level` ≥ this value; legal range 1..DEPTH.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all contents.
- `wr_valid`  in  1  write request.
- `wr_data`  in  WIDTH  write word.
- `wr_ready`  out  1  FIFO can accept a word.
- `rd_data`  out  WIDTH  head word, valid while `rd_valid`.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer pops the head word.
- `level`  out  $clog2(DEPTH)+1  number of words held.
- `almost_full`  out  1  `level` ≥ `AFULL_THRESH`.

## Operation
- Handshakes:
  - A write occurs when `wr_valid & wr_ready` at a rising edge.
  - A read occurs when `rd_valid & rd_ready` at a rising edge.
  - `wr_valid` and `rd_ready` high against a deasserted partner are legal stalls. No data is lost and no state changes.
- Storage: circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `level` is kept as an explicit counter.
- Level update per cycle: write only +1; read only −1; both or neither unchanged.
- Full (`level` = DEPTH): `wr_ready` = 0. A read in that cycle does not enable a same-cycle write; there is no pass-through.
- Empty (`level` = 0): `rd_valid` = 0. A write in that cycle does not bypass to the output.
- Show-ahead: `rd_data` is the head word whenever `rd_valid` = 1. It is undefined (don't-care) when empty.
- Flush:
  - Takes priority over reads and writes in the same cycle; neither is counted.
  - Pointers and `level` are zero after the edge.
  - `wr_ready` = 0 and `rd_valid` = 0 during the cycle in which `flush` is high.
- Reset clears the pointers, `level` and the output stage. Memory contents are not reset.

## Timing
- Reset values: `wr_ready` 0 while `rst` is high, then 1 from the first cycle after release. `rd_valid` 0, `level` 0, `almost_full` 0, `rd_data` don't-care.
- Without the output register, a write accepted at edge N gives `rd_valid` = 1 and the word on `rd_data` in cycle N+1.
- A read at edge N presents the next word, or `rd_valid` = 0, in cycle N+1.
- `level` and `almost_full` are registered. They reflect all transfers up to and including the last edge.
- `wr_ready` and `rd_valid` are decoded from registered state only. Neither depends combinationally on `wr_valid` or `rd_ready`.
- Sustained throughput is one word per cycle in each direction, including at wrap-around.

## Configuration
- Macro: `PRACH_BUFFER_CP_SFIFO_OREG_EN`.
- Defined:
  - `rd_data` and `rd_valid` come from a one-entry prefetch register fed from the RAM, so RAM read data is registered before the outputs.
  - Write-to-`rd_valid` latency is 2 cycles.
  - The prefetch entry counts in `level`, so capacity is still DEPTH and `wr_ready` is still `level` < DEPTH.
  - Full throughput is retained.
- Undefined: combinational RAM read to `rd_data` with 1-cycle latency, as in Operation.

## Structure
- Package `prach_buffer_pkg`:
  - a localparam function for the pointer width from DEPTH;
  - a constant for the default almost-full margin (4).
- Sub-module `prach_buffer_sdpram`: simple dual-port RAM with one write port and one asynchronous read port, parameters WIDTH and DEPTH. Pointers, counter, flags and the prefetch stage stay in the top module.

## Test plan
- Reset then fill: reset with `wr_valid` held high, release, write 0..15 (DEPTH=16).
  - `wr_ready` drops after the 16th write.
  - `level`=16 and `almost_full` rises when `level`=12.
  - Draining yields 0..15 in order.
- Simultaneous read and write at steady state: `level`=8, 100 cycles of `wr_valid`=`rd_ready`=1.
  - `level` stays 8 and the output sequence is contiguous across pointer wrap.
- Full stall: `level`=16, `wr_valid`=1 and `rd_ready`=1 in the same cycle.
  - Only the read occurs; `level`=15.
  - The write lands the next cycle; `level` returns to 16.
- Empty stall: `level`=0, `rd_ready`=1 and `wr_valid`=1 with data 0xA5.
  - `rd_valid`=0 in that cycle; `rd_valid`=1 with 0xA5 in the next cycle (the cycle after that with OREG).
- Flush mid-stream: `level`=7, assert `flush` with `wr_valid`=`rd_ready`=1.
  - `level`=0 and `rd_valid`=0 next cycle; a new write of 0x1 is the first word read.
- Async reset mid-operation: assert `rst` between edges at `level`=5.
  - Outputs go to reset values immediately and no stale data is read after release.
